// File: rtl/n64adv_vout_stage.sv
// n64adv_vout_stage
// Final PPU output stage in the VCLK_Tx domain. It registers sync and colour
// onto the DAC pins, optionally exchanges the outer colour channels, drives the
// Filter AddOn / VGA H/V-sync jumper pins, and mutes video for a number of
// vsync falling edges after every mode or line-multiplier change.
// Optional feature macro: VOUT_BLANK_ZERO_EN (forces colour to zero while nBLANK is low).

module n64adv_vout_stage #(
    parameter int COLOR_W     = 8,
    parameter int NCH         = 3,
    parameter int MUTE_FRAMES = 2
) (
    input  logic                       VCLK_Tx,
    input  logic                       VRST_Tx,
    input  logic                       vdata_valid_i,
    input  logic [4+NCH*COLOR_W-1:0]   vdata_i,
    input  logic                       cfg_swap_i,
    input  logic                       cfg_csync_en_i,
    input  logic                       cfg_use_hvsync_i,
    input  logic [2:0]                 cfg_filter_i,
    input  logic [1:0]                 linemult_i,
    input  logic [1:0]                 mode_i,
    output logic [NCH*COLOR_W-1:0]     vd_o,
    output logic [1:0]                 nCSYNC_o,
    output logic                       nVSYNC_or_F2_o,
    output logic                       nHSYNC_or_F1_o,
    output logic [1:0]                 filter_o,
    output logic                       muted_o
);

    localparam int         DW = NCH * COLOR_W;
    localparam logic [3:0] MF = 4'(MUTE_FRAMES);

    typedef enum logic {
        RUN  = 1'b0,
        MUTE = 1'b1
    } mute_state_t;

    mute_state_t   state;
    logic [3:0]    frame_cnt;
    logic [3:0]    frame_cnt_inc;
    logic [3:0]    cfg_prev;
    logic [3:0]    cfg_now;
    logic          vsync_prev;

    logic          nvsync_in;
    logic          nblank_in;
    logic          nhsync_in;
    logic          ncsync_in;
    logic [DW-1:0] color_in;
    logic [DW-1:0] color_perm;
    logic [1:0]    filter_res;
    logic          blank_zero;
    logic          chg;
    logic          vfall;
    logic          mute_done;
    logic          mute_next;

    assign nvsync_in = vdata_i[DW+3];
    assign nblank_in = vdata_i[DW+2];
    assign nhsync_in = vdata_i[DW+1];
    assign ncsync_in = vdata_i[DW];
    assign color_in  = vdata_i[DW-1:0];

    // Exchange the outermost colour channels when requested; middle channels stay put
    always_comb begin
        color_perm = color_in;
        if (cfg_swap_i) begin
            color_perm[COLOR_W-1:0]   = color_in[DW-1 -: COLOR_W];
            color_perm[DW-1 -: COLOR_W] = color_in[COLOR_W-1:0];
        end
    end

    // Resolve the filter selection: auto follows the line multiplier, 1xx means bypass
    always_comb begin
        filter_res = 2'b11;
        if (!cfg_filter_i[2]) begin
            if (cfg_filter_i[1:0] == 2'b00)
                filter_res = linemult_i;
            else
                filter_res = cfg_filter_i[1:0] - 2'd1;
        end
    end

`ifdef VOUT_BLANK_ZERO_EN
    assign blank_zero = vdata_valid_i & ~nblank_in;
`else
    // Blanking is not acted upon here; colour passes through untouched
    assign blank_zero = nblank_in & 1'b0;
`endif

    assign cfg_now       = {linemult_i, mode_i};
    assign chg           = (cfg_now != cfg_prev);
    assign vfall         = vdata_valid_i & ~nvsync_in & vsync_prev;
    assign frame_cnt_inc = (frame_cnt == 4'hF) ? frame_cnt : frame_cnt + 4'd1;
    assign mute_done     = (MF == 4'd0) | (vfall & (frame_cnt_inc >= MF));
    assign mute_next     = chg | ((state == MUTE) & ~mute_done);

    // Mute FSM: any mode change restarts the mute, vsync falling edges count it down
    always_ff @(posedge VCLK_Tx) begin
        if (VRST_Tx) begin
            state      <= MUTE;
            frame_cnt  <= 4'd0;
            cfg_prev   <= 4'd0;
            vsync_prev <= 1'b0;
            muted_o    <= 1'b1;
        end else begin
            cfg_prev <= cfg_now;
            if (vdata_valid_i)
                vsync_prev <= nvsync_in;
            if (chg) begin
                state     <= MUTE;
                frame_cnt <= 4'd0;
            end else if (state == MUTE) begin
                if (vfall)
                    frame_cnt <= frame_cnt_inc;
                if (mute_done)
                    state <= RUN;
            end
            muted_o <= mute_next;
        end
    end

    // Register the resolved filter code every cycle
    always_ff @(posedge VCLK_Tx) begin
        if (VRST_Tx)
            filter_o <= 2'b00;
        else
            filter_o <= filter_res;
    end

    // DAC data path, composite sync pins and jumper pins
    always_ff @(posedge VCLK_Tx) begin
        if (VRST_Tx) begin
            vd_o           <= '0;
            nCSYNC_o       <= 2'b00;
            nVSYNC_or_F2_o <= 1'b0;
            nHSYNC_or_F1_o <= 1'b0;
        end else begin
            if (mute_next)
                vd_o <= '0;
            else if (vdata_valid_i)
                vd_o <= blank_zero ? '0 : color_perm;

            if (vdata_valid_i)
                nCSYNC_o <= {ncsync_in, ncsync_in & cfg_csync_en_i};

            if (cfg_use_hvsync_i) begin
                if (vdata_valid_i) begin
                    nVSYNC_or_F2_o <= nvsync_in;
                    nHSYNC_or_F1_o <= nhsync_in;
                end
            end else begin
                nVSYNC_or_F2_o <= filter_o[1];
                nHSYNC_or_F1_o <= filter_o[0];
            end
        end
    end

endmodule

// File: tb/tb_n64adv_vout_stage.sv
// tb_n64adv_vout_stage
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the output stage kept in this file.

module tb_n64adv_vout_stage;

    localparam int COLOR_W     = 8;
    localparam int NCH         = 3;
    localparam int MUTE_FRAMES = 2;
    localparam int DW          = NCH * COLOR_W;

    logic              VCLK_Tx = 1'b0;
    logic              VRST_Tx;
    logic              vdata_valid_i;
    logic [DW+3:0]     vdata_i;
    logic              cfg_swap_i;
    logic              cfg_csync_en_i;
    logic              cfg_use_hvsync_i;
    logic [2:0]        cfg_filter_i;
    logic [1:0]        linemult_i;
    logic [1:0]        mode_i;
    logic [DW-1:0]     vd_o;
    logic [1:0]        nCSYNC_o;
    logic              nVSYNC_or_F2_o;
    logic              nHSYNC_or_F1_o;
    logic [1:0]        filter_o;
    logic              muted_o;

    int nChecks = 0;
    int nErrors = 0;

    // model state
    logic [DW-1:0] expVd;
    logic [1:0]    expCsync;
    logic          expPinF2;
    logic          expPinF1;
    logic [1:0]    expFilter;
    logic          expMuted;
    int            framesSeen;
    logic [3:0]    lastCfg;
    logic          lastVsync;

    n64adv_vout_stage #(
        .COLOR_W    (COLOR_W),
        .NCH        (NCH),
        .MUTE_FRAMES(MUTE_FRAMES)
    ) dut (
        .VCLK_Tx         (VCLK_Tx),
        .VRST_Tx         (VRST_Tx),
        .vdata_valid_i   (vdata_valid_i),
        .vdata_i         (vdata_i),
        .cfg_swap_i      (cfg_swap_i),
        .cfg_csync_en_i  (cfg_csync_en_i),
        .cfg_use_hvsync_i(cfg_use_hvsync_i),
        .cfg_filter_i    (cfg_filter_i),
        .linemult_i      (linemult_i),
        .mode_i          (mode_i),
        .vd_o            (vd_o),
        .nCSYNC_o        (nCSYNC_o),
        .nVSYNC_or_F2_o  (nVSYNC_or_F2_o),
        .nHSYNC_or_F1_o  (nHSYNC_or_F1_o),
        .filter_o        (filter_o),
        .muted_o         (muted_o)
    );

    always #5 VCLK_Tx = ~VCLK_Tx;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] resolveFilter(input logic [2:0] sel, input logic [1:0] lm);
        int code;
        if (sel >= 3'd4)
            code = 3;
        else if (sel == 3'd0)
            code = int'(lm);
        else
            code = int'(sel) - 1;
        return 2'(code);
    endfunction

    function automatic logic [DW-1:0] permute(input logic [DW-1:0] d, input logic sw);
        logic [COLOR_W-1:0] ch [NCH];
        logic [COLOR_W-1:0] tmp;
        logic [DW-1:0]      res;
        for (int i = 0; i < NCH; i++)
            ch[i] = d[i*COLOR_W +: COLOR_W];
        if (sw) begin
            tmp         = ch[0];
            ch[0]       = ch[NCH-1];
            ch[NCH-1]   = tmp;
        end
        res = '0;
        for (int i = 0; i < NCH; i++)
            res[i*COLOR_W +: COLOR_W] = ch[i];
        return res;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled
    task automatic modelStep();
        logic [3:0] syncIn;
        logic       fell;
        logic       blanked;
        syncIn = vdata_i[DW+3:DW];
        if (VRST_Tx) begin
            expVd      = '0;
            expCsync   = 2'b00;
            expPinF2   = 1'b0;
            expPinF1   = 1'b0;
            expFilter  = 2'b00;
            expMuted   = 1'b1;
            framesSeen = 0;
            lastCfg    = 4'd0;
            lastVsync  = 1'b0;
        end else begin
            fell = vdata_valid_i && !syncIn[3] && lastVsync;
            if (vdata_valid_i)
                lastVsync = syncIn[3];
            if ({linemult_i, mode_i} != lastCfg) begin
                expMuted   = 1'b1;
                framesSeen = 0;
            end else if (expMuted) begin
                if (fell)
                    framesSeen++;
                if (framesSeen >= MUTE_FRAMES)
                    expMuted = 1'b0;
            end
            lastCfg = {linemult_i, mode_i};

            if (!cfg_use_hvsync_i) begin
                expPinF2 = expFilter[1];
                expPinF1 = expFilter[0];
            end else if (vdata_valid_i) begin
                expPinF2 = syncIn[3];
                expPinF1 = syncIn[1];
            end
            expFilter = resolveFilter(cfg_filter_i, linemult_i);

`ifdef VOUT_BLANK_ZERO_EN
            blanked = !syncIn[2];
`else
            blanked = 1'b0;
`endif
            if (expMuted)
                expVd = '0;
            else if (vdata_valid_i)
                expVd = blanked ? '0 : permute(vdata_i[DW-1:0], cfg_swap_i);

            if (vdata_valid_i)
                expCsync = {syncIn[0], syncIn[0] & cfg_csync_en_i};
        end
    endtask

    task automatic checkAll();
        checkOutput("vd_o", 32'(vd_o), 32'(expVd));
        checkOutput("nCSYNC_o", 32'(nCSYNC_o), 32'(expCsync));
        checkOutput("pinF2", 32'(nVSYNC_or_F2_o), 32'(expPinF2));
        checkOutput("pinF1", 32'(nHSYNC_or_F1_o), 32'(expPinF1));
        checkOutput("filter_o", 32'(filter_o), 32'(expFilter));
        checkOutput("muted_o", 32'(muted_o), 32'(expMuted));
    endtask

    task automatic tick();
        @(posedge VCLK_Tx);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] sync, input logic [DW-1:0] ch);
        vdata_valid_i = valid;
        vdata_i       = {sync, ch};
        tick();
    endtask

    task automatic vsyncFall(input logic [DW-1:0] ch);
        applyStimulus(1'b1, 4'hF, ch);
        applyStimulus(1'b1, 4'h7, ch);
    endtask

    logic [DW-1:0] heldVd;
    logic [1:0]    heldCsync;

    initial begin
        VRST_Tx          = 1'b1;
        vdata_valid_i    = 1'b0;
        vdata_i          = '0;
        cfg_swap_i       = 1'b1;
        cfg_csync_en_i   = 1'b1;
        cfg_use_hvsync_i = 1'b1;
        cfg_filter_i     = 3'b000;
        linemult_i       = 2'b00;
        mode_i           = 2'b00;

        // reset held for three cycles
        for (int i = 0; i < 3; i++)
            tick();
        checkOutput("rst_vd", 32'(vd_o), 32'h0);
        checkOutput("rst_csync", 32'(nCSYNC_o), 32'h0);
        checkOutput("rst_muted", 32'(muted_o), 32'h1);
        VRST_Tx = 1'b0;

        // mute holds until the second vsync falling edge
        applyStimulus(1'b1, 4'hF, 24'h112233);
        applyStimulus(1'b1, 4'hF, 24'h112233);
        checkOutput("mute_pre", 32'(muted_o), 32'h1);
        vsyncFall(24'h112233);
        checkOutput("mute_1fall", 32'(muted_o), 32'h1);
        vsyncFall(24'h112233);
        checkOutput("mute_2fall", 32'(muted_o), 32'h0);

        // channel swap and csync gating
        applyStimulus(1'b1, 4'hF, 24'h112233);
        checkOutput("swap_vd", 32'(vd_o), 32'h332211);
        checkOutput("csync_en1", 32'(nCSYNC_o), 32'h3);
        cfg_csync_en_i = 1'b0;
        applyStimulus(1'b1, 4'hF, 24'h112233);
        checkOutput("csync_en0", 32'(nCSYNC_o), 32'h2);
        cfg_csync_en_i = 1'b1;

        // invalid samples leave the data path untouched
        heldVd    = vd_o;
        heldCsync = nCSYNC_o;
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 4'($urandom), DW'($urandom));
        checkOutput("hold_vd", 32'(vd_o), 32'(heldVd));
        checkOutput("hold_csync", 32'(nCSYNC_o), 32'(heldCsync));

        // blanking behaviour depends on the build option
        applyStimulus(1'b1, 4'b1011, 24'hFFFFFF);
`ifdef VOUT_BLANK_ZERO_EN
        checkOutput("blank_vd", 32'(vd_o), 32'h0);
`else
        checkOutput("blank_vd", 32'(vd_o), 32'hFFFFFF);
`endif
        applyStimulus(1'b1, 4'b1111, 24'hFFFFFF);
        checkOutput("unblank_vd", 32'(vd_o), 32'hFFFFFF);

        // filter resolution and jumper pins in filter mode
        cfg_use_hvsync_i = 1'b0;
        cfg_filter_i     = 3'b000;
        linemult_i       = 2'b01;
        applyStimulus(1'b1, 4'hF, 24'h445566);
        checkOutput("filt_auto", 32'(filter_o), 32'h1);
        cfg_filter_i = 3'b011;
        applyStimulus(1'b1, 4'hF, 24'h445566);
        checkOutput("filt_hd", 32'(filter_o), 32'h2);
        checkOutput("pins_auto", 32'({nVSYNC_or_F2_o, nHSYNC_or_F1_o}), 32'h1);
        cfg_filter_i = 3'b100;
        applyStimulus(1'b1, 4'hF, 24'h445566);
        checkOutput("filt_byp", 32'(filter_o), 32'h3);
        checkOutput("pins_hd", 32'({nVSYNC_or_F2_o, nHSYNC_or_F1_o}), 32'h2);
        applyStimulus(1'b1, 4'hF, 24'h445566);
        checkOutput("pins_byp", 32'({nVSYNC_or_F2_o, nHSYNC_or_F1_o}), 32'h3);

        // back to RUN with original line multiplier
        cfg_use_hvsync_i = 1'b1;
        cfg_filter_i     = 3'b000;
        linemult_i       = 2'b00;
        applyStimulus(1'b1, 4'hF, 24'h445566);
        vsyncFall(24'h445566);
        vsyncFall(24'h445566);
        checkOutput("rerun", 32'(muted_o), 32'h0);

        // mode change mutes; a second change restarts the count
        mode_i = 2'b10;
        applyStimulus(1'b1, 4'hF, 24'h778899);
        checkOutput("chg_muted", 32'(muted_o), 32'h1);
        checkOutput("chg_vd", 32'(vd_o), 32'h0);
        vsyncFall(24'h778899);
        mode_i = 2'b00;
        applyStimulus(1'b1, 4'hF, 24'h778899);
        vsyncFall(24'h778899);
        checkOutput("restart_1", 32'(muted_o), 32'h1);
        vsyncFall(24'h778899);
        checkOutput("restart_2", 32'(muted_o), 32'h0);

        // randomized traffic
        begin
            logic vs;
            vs = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                VRST_Tx = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    linemult_i = 2'($urandom);
                    mode_i     = 2'($urandom);
                end
                if ($urandom_range(0, 15) == 0) begin
                    cfg_swap_i       = 1'($urandom);
                    cfg_csync_en_i   = 1'($urandom);
                    cfg_use_hvsync_i = 1'($urandom);
                end
                if ($urandom_range(0, 9) == 0)
                    cfg_filter_i = 3'($urandom);
                if ($urandom_range(0, 5) == 0)
                    vs = ~vs;
                applyStimulus(($urandom_range(0, 3) != 0), {vs, 3'($urandom)}, DW'($urandom));
            end
            VRST_Tx = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
